// File: rtl/ht_cmd_traffic_gen_pkg.sv
// ---------------------------------------------------------------------------
// ht_cmd_traffic_gen_pkg
// Shared types and constants for the hash table command traffic generator.
//   ht_opcode_t       : command opcode seen by the hash table command input
//   gen_mode_t        : traffic generator run mode
//   gen_state_t       : traffic generator control states
//   HT_GEN_LFSR_TAPS  : feedback taps of the 32-bit right-shifting Galois LFSR
//   ht_gen_lfsr_next  : one LFSR step
// ---------------------------------------------------------------------------
package ht_cmd_traffic_gen_pkg;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_INSERT = 2'd1,
    OP_SEARCH = 2'd2,
    OP_DELETE = 2'd3
  } ht_opcode_t;

  typedef enum logic [1:0] {
    MODE_INIT       = 2'd0,
    MODE_SEQ_INSERT = 2'd1,
    MODE_SEQ_SEARCH = 2'd2,
    MODE_RANDOM     = 2'd3
  } gen_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_DRAIN = 2'd2
  } gen_state_t;

  localparam logic [31:0] HT_GEN_LFSR_TAPS = 32'h8020_0003;

  // Galois form: the bit shifted out decides whether the taps are folded in.
  function automatic logic [31:0] ht_gen_lfsr_next(input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ HT_GEN_LFSR_TAPS;
    return nxt;
  endfunction

endpackage

// File: rtl/ht_gen_lfsr.sv
// ---------------------------------------------------------------------------
// ht_gen_lfsr
// 32-bit Galois LFSR (shift right, taps HT_GEN_LFSR_TAPS) used as the random
// source of the traffic generator.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads SEED
//   load  : synchronous reload of SEED (has priority over step)
//   step  : advance the sequence by one step
//   lfsr  : current LFSR value
// ---------------------------------------------------------------------------
module ht_gen_lfsr
  import ht_cmd_traffic_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [31:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= ht_gen_lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/ht_cmd_traffic_gen.sv
// ---------------------------------------------------------------------------
// ht_cmd_traffic_gen
// Command generator for the hash table pipeline: issues INIT, sequential
// insert, sequential search or constrained-random commands over a valid/ready
// stream, consumes the result stream, and limits commands in flight.
// Ports:
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   start_i               : start a run (only honoured in IDLE)
//   mode_i                : run mode (gen_mode_t encoding)
//   cmd_cnt_i             : commands to issue (ignored in INIT)
//   key_base_i            : first key for the sequential modes
//   bucket_base_i/mask_i  : random bucket = base | (lfsr bits & mask)
//   low_mask_i            : random low key = lfsr bits & mask
//   cmd_*                 : command stream towards the hash table
//   res_valid_i/ready_o   : result stream (always ready)
//   busy_o, done_o        : run active / one-cycle completion pulse
//   sent_cnt_o/rcvd_cnt_o : per-run command and result counters
//   unexpected_o          : sticky, result seen with nothing outstanding
// ---------------------------------------------------------------------------
module ht_cmd_traffic_gen
  import ht_cmd_traffic_gen_pkg::*;
#(
  parameter int          KEY_WIDTH       = 32,
  parameter int          VALUE_WIDTH     = 16,
  parameter int          BUCKET_WIDTH    = 8,
  parameter int          CNT_WIDTH       = 32,
  parameter int          MAX_OUTSTANDING = 16,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              start_i,
  input  logic [1:0]                        mode_i,
  input  logic [CNT_WIDTH-1:0]              cmd_cnt_i,
  input  logic [KEY_WIDTH-1:0]              key_base_i,
  input  logic [BUCKET_WIDTH-1:0]           bucket_base_i,
  input  logic [BUCKET_WIDTH-1:0]           bucket_mask_i,
  input  logic [KEY_WIDTH-BUCKET_WIDTH-1:0] low_mask_i,
  output logic                              cmd_valid_o,
  input  logic                              cmd_ready_i,
  output ht_opcode_t                        cmd_opcode_o,
  output logic [KEY_WIDTH-1:0]              cmd_key_o,
  output logic [VALUE_WIDTH-1:0]            cmd_value_o,
  input  logic                              res_valid_i,
  output logic                              res_ready_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [CNT_WIDTH-1:0]              sent_cnt_o,
  output logic [CNT_WIDTH-1:0]              rcvd_cnt_o,
  output logic                              unexpected_o
);

  localparam int LOW_WIDTH = KEY_WIDTH - BUCKET_WIDTH;
  localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = OUT_WIDTH'(MAX_OUTSTANDING);

  gen_state_t                  state;
  gen_state_t                  state_next;
  gen_mode_t                   mode;
  logic [CNT_WIDTH-1:0]        cnt_total;
  logic [CNT_WIDTH-1:0]        total_cmds;
  logic [KEY_WIDTH-1:0]        key_base;
  logic [BUCKET_WIDTH-1:0]     bucket_base;
  logic [BUCKET_WIDTH-1:0]     bucket_mask;
  logic [LOW_WIDTH-1:0]        low_mask;
  logic [OUT_WIDTH-1:0]        outstanding;
  logic [OUT_WIDTH-1:0]        out_next;
  logic [31:0]                 lfsr;
  logic                        accept;
  logic                        start_run;
  logic                        last_accept;
  logic [BUCKET_WIDTH-1:0]     rnd_bucket;
  logic [LOW_WIDTH-1:0]        rnd_low;

  assign accept      = cmd_valid_o & cmd_ready_i;
  assign start_run   = (state == ST_IDLE) & start_i;
  assign total_cmds  = (mode == MODE_INIT) ? CNT_WIDTH'(1) : cnt_total;
  assign last_accept = accept & ((sent_cnt_o + CNT_WIDTH'(1)) == total_cmds);
  assign busy_o      = (state != ST_IDLE);
  assign res_ready_o = 1'b1;

  ht_gen_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .load  (start_run),
    .step  (accept && (mode == MODE_RANDOM)),
    .lfsr  (lfsr)
  );

  // A command and a result in the same cycle cancel out; a result with nothing
  // in flight cannot take the counter below zero.
  always_comb begin
    out_next = outstanding;
    if (accept && !res_valid_i) begin
      out_next = outstanding + OUT_WIDTH'(1);
    end else if (!accept && res_valid_i && (outstanding != '0)) begin
      out_next = outstanding - OUT_WIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          if ((gen_mode_t'(mode_i) != MODE_INIT) && (cmd_cnt_i == '0)) begin
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_GEN;
          end
        end
      end
      ST_GEN: begin
        if (last_accept) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outstanding == '0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // cmd_valid_o and done_o are registered from the next-state view so that the
  // valid flag already reflects the in-flight limit on the cycle it is seen.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      mode         <= MODE_INIT;
      cnt_total    <= '0;
      key_base     <= '0;
      bucket_base  <= '0;
      bucket_mask  <= '0;
      low_mask     <= '0;
      outstanding  <= '0;
      cmd_valid_o  <= 1'b0;
      done_o       <= 1'b0;
      sent_cnt_o   <= '0;
      rcvd_cnt_o   <= '0;
      unexpected_o <= 1'b0;
    end else begin
      state       <= state_next;
      outstanding <= out_next;
      cmd_valid_o <= (state_next == ST_GEN) && (out_next < OUT_MAX);
      done_o      <= (state == ST_DRAIN) && (state_next == ST_IDLE);
      if (start_run) begin
        mode         <= gen_mode_t'(mode_i);
        cnt_total    <= cmd_cnt_i;
        key_base     <= key_base_i;
        bucket_base  <= bucket_base_i;
        bucket_mask  <= bucket_mask_i;
        low_mask     <= low_mask_i;
        sent_cnt_o   <= '0;
        rcvd_cnt_o   <= '0;
        unexpected_o <= 1'b0;
      end else begin
        if (accept) sent_cnt_o <= sent_cnt_o + CNT_WIDTH'(1);
        if (res_valid_i) begin
          rcvd_cnt_o <= rcvd_cnt_o + CNT_WIDTH'(1);
          if (outstanding == '0) unexpected_o <= 1'b1;
        end
      end
    end
  end

  // The command index always equals the accepted count of the run, so
  // sent_cnt_o doubles as the sequential index. Content depends only on
  // registered state, which keeps it stable while the consumer stalls.
  always_comb begin
    rnd_bucket = bucket_base | (lfsr[31 -: BUCKET_WIDTH] & bucket_mask);
    rnd_low    = lfsr[LOW_WIDTH-1:0] & low_mask;
    cmd_opcode_o = OP_INIT;
    cmd_key_o    = '0;
    cmd_value_o  = '0;
    case (mode)
      MODE_SEQ_INSERT: begin
        cmd_opcode_o = OP_INSERT;
        cmd_key_o    = key_base + KEY_WIDTH'(sent_cnt_o);
        cmd_value_o  = VALUE_WIDTH'(sent_cnt_o);
      end
      MODE_SEQ_SEARCH: begin
        cmd_opcode_o = OP_SEARCH;
        cmd_key_o    = key_base + KEY_WIDTH'(sent_cnt_o);
      end
      MODE_RANDOM: begin
        cmd_key_o = {rnd_bucket, rnd_low};
        case (lfsr[17:16])
          2'b00:   cmd_opcode_o = OP_SEARCH;
          2'b10:   cmd_opcode_o = OP_DELETE;
          default: begin
            cmd_opcode_o = OP_INSERT;
            cmd_value_o  = lfsr[31 -: VALUE_WIDTH];
          end
        endcase
      end
      default: begin
        cmd_opcode_o = OP_INIT;
      end
    endcase
  end

endmodule
